// File: rtl/fetch_stage_v2.sv
// Instruction-fetch stage with IF/ID register: stall, redirect/flush, and
// one- or two-word instructions (opcode word plus optional immediate word).
module fetch_stage_v2 #(
  parameter int unsigned IW       = 16,
  parameter int unsigned PCW      = 32,
  parameter int unsigned RESET_PC = 32,
  parameter int unsigned EXT_BIT  = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           redirect,
  input  logic [PCW-1:0] redirect_pc,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  output logic           id_valid,
  output logic [IW-1:0]  id_instruction,
  output logic [IW-1:0]  id_immediate,
  output logic           id_has_imm,
  output logic [PCW-1:0] id_pc,
  output logic [PCW-1:0] id_pc_next
);

  typedef enum logic {
    FETCH     = 1'b0,
    FETCH_IMM = 1'b1
  } state_t;

  state_t         state;
  logic [PCW-1:0] pc;
  logic [IW-1:0]  first_word;
  logic [PCW-1:0] first_pc;
  logic [PCW-1:0] pc_inc;

  // The memory is addressed directly by the PC; increment wraps modulo 2^PCW.
  assign imem_addr = pc;
  assign pc_inc    = pc + PCW'(1);

  // Priority: reset > redirect > stall > normal fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= PCW'(RESET_PC);
      state          <= FETCH;
      first_word     <= '0;
      first_pc       <= '0;
      id_valid       <= 1'b0;
      id_instruction <= '0;
      id_immediate   <= '0;
      id_has_imm     <= 1'b0;
      id_pc          <= '0;
      id_pc_next     <= '0;
    end else if (redirect) begin
      // Flush: any pending opcode word is dropped by returning to FETCH.
      pc       <= redirect_pc;
      state    <= FETCH;
      id_valid <= 1'b0;
    end else if (!stall) begin
      unique case (state)
        FETCH: begin
          pc <= pc_inc;
          if (imem_data[EXT_BIT]) begin
            first_word <= imem_data;
            first_pc   <= pc;
            state      <= FETCH_IMM;
            id_valid   <= 1'b0;
          end else begin
            id_valid       <= 1'b1;
            id_instruction <= imem_data;
            id_immediate   <= '0;
            id_has_imm     <= 1'b0;
            id_pc          <= pc;
            id_pc_next     <= pc_inc;
          end
        end
        FETCH_IMM: begin
          pc             <= pc_inc;
          state          <= FETCH;
          id_valid       <= 1'b1;
          id_instruction <= first_word;
          id_immediate   <= imem_data;
          id_has_imm     <= 1'b1;
          id_pc          <= first_pc;
          id_pc_next     <= pc_inc;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage_v2.sv
// Directed plus randomized bench for fetch_stage_v2 against a queue-based
// instruction-stream model.
module tb_fetch_stage_v2;

  localparam int unsigned IW       = 16;
  localparam int unsigned PCW      = 32;
  localparam int unsigned RESET_PC = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           stall = 1'b0;
  logic           redirect = 1'b0;
  logic [PCW-1:0] redirect_pc = '0;
  logic [PCW-1:0] imem_addr;
  logic [IW-1:0]  imem_data;
  logic           id_valid;
  logic [IW-1:0]  id_instruction;
  logic [IW-1:0]  id_immediate;
  logic           id_has_imm;
  logic [PCW-1:0] id_pc;
  logic [PCW-1:0] id_pc_next;

  // 256-word memory aliased on the low address byte.
  logic [IW-1:0] mem [256];
  assign imem_data = mem[imem_addr[7:0]];

  fetch_stage_v2 #(.IW(IW), .PCW(PCW), .RESET_PC(RESET_PC), .EXT_BIT(0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .id_valid(id_valid), .id_instruction(id_instruction),
    .id_immediate(id_immediate), .id_has_imm(id_has_imm), .id_pc(id_pc),
    .id_pc_next(id_pc_next)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: the words gathered for the instruction in progress sit in a queue.
  logic [PCW-1:0] m_pc;
  logic [IW-1:0]  m_q[$];
  logic [PCW-1:0] m_qpc;
  logic           m_valid;
  logic [IW-1:0]  m_ins, m_imm;
  logic           m_has;
  logic [PCW-1:0] m_idpc, m_next;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [IW-1:0] w;
    if (reset) begin
      m_pc = PCW'(RESET_PC); m_q.delete(); m_qpc = '0;
      m_valid = 0; m_ins = '0; m_imm = '0; m_has = 0; m_idpc = '0; m_next = '0;
    end else if (redirect) begin
      m_pc = redirect_pc; m_q.delete(); m_valid = 0;
    end else if (!stall) begin
      w = mem[m_pc[7:0]];
      if (m_q.size() == 0 && w[0]) begin
        m_q.push_back(w); m_qpc = m_pc; m_valid = 0;
      end else if (m_q.size() == 0) begin
        m_valid = 1; m_ins = w; m_imm = '0; m_has = 0;
        m_idpc = m_pc; m_next = m_pc + 1;
      end else begin
        m_valid = 1; m_ins = m_q[0]; m_imm = w; m_has = 1;
        m_idpc = m_qpc; m_next = m_pc + 1;
        m_q.delete();
      end
      m_pc = m_pc + 1;
    end
  endtask

  task automatic check_model();
    chk("m_imem_addr", 64'(imem_addr), 64'(m_pc));
    chk("m_id_valid", 64'(id_valid), 64'(m_valid));
    chk("m_id_instruction", 64'(id_instruction), 64'(m_ins));
    chk("m_id_immediate", 64'(id_immediate), 64'(m_imm));
    chk("m_id_has_imm", 64'(id_has_imm), 64'(m_has));
    chk("m_id_pc", 64'(id_pc), 64'(m_idpc));
    chk("m_id_pc_next", 64'(id_pc_next), 64'(m_next));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[32]  = 16'h1000;
    mem[33]  = 16'h2001;
    mem[34]  = 16'hABCD;
    mem[35]  = 16'h0004;
    mem[100] = 16'h0042;
    mem[255] = 16'h3001;
    mem[0]   = 16'h5555;

    // 1: reset state then first one-word fetch
    reset = 1; step(); step();
    chk("rst_addr", 64'(imem_addr), 64'd32);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_instr", 64'(id_instruction), 64'd0);
    chk("rst_pc_next", 64'(id_pc_next), 64'd0);
    reset = 0; step();
    chk("t1_valid", 64'(id_valid), 64'd1);
    chk("t1_instr", 64'(id_instruction), 64'h1000);
    chk("t1_pc", 64'(id_pc), 64'd32);
    chk("t1_pc_next", 64'(id_pc_next), 64'd33);
    chk("t1_addr", 64'(imem_addr), 64'd33);

    // 2: two-word instruction with one bubble
    step();
    chk("t2_bubble", 64'(id_valid), 64'd0);
    step();
    chk("t2_valid", 64'(id_valid), 64'd1);
    chk("t2_instr", 64'(id_instruction), 64'h2001);
    chk("t2_imm", 64'(id_immediate), 64'hABCD);
    chk("t2_has", 64'(id_has_imm), 64'd1);
    chk("t2_pc", 64'(id_pc), 64'd33);
    chk("t2_pc_next", 64'(id_pc_next), 64'd35);

    // 3: stall inside FETCH_IMM
    redirect = 1; redirect_pc = 33; step();
    redirect = 0; step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold_addr", 64'(imem_addr), 64'd34);
      chk("t3_hold_valid", 64'(id_valid), 64'd0);
    end
    stall = 0; step();
    chk("t3_valid", 64'(id_valid), 64'd1);
    chk("t3_imm", 64'(id_immediate), 64'hABCD);
    chk("t3_pc_next", 64'(id_pc_next), 64'd35);

    // 4: redirect beats stall in FETCH_IMM; partial word dropped
    redirect = 1; redirect_pc = 33; step();
    redirect = 0; step();
    stall = 1; redirect = 1; redirect_pc = 100; step();
    chk("t4_addr", 64'(imem_addr), 64'd100);
    chk("t4_valid", 64'(id_valid), 64'd0);
    stall = 0; redirect = 0; step();
    chk("t4_instr", 64'(id_instruction), 64'h0042);
    chk("t4_pc", 64'(id_pc), 64'd100);
    chk("t4_has", 64'(id_has_imm), 64'd0);

    // 5: immediate address wraps to 0
    redirect = 1; redirect_pc = 32'hFFFF_FFFF; step();
    redirect = 0; step();
    chk("t5_addr_wrap", 64'(imem_addr), 64'd0);
    step();
    chk("t5_pc", 64'(id_pc), 64'hFFFF_FFFF);
    chk("t5_imm", 64'(id_immediate), 64'h5555);
    chk("t5_pc_next", 64'(id_pc_next), 64'd1);

    // 6: reset after first word discards partial instruction
    redirect = 1; redirect_pc = 33; step();
    redirect = 0; step();
    reset = 1; step();
    chk("t6_addr", 64'(imem_addr), 64'd32);
    chk("t6_valid", 64'(id_valid), 64'd0);
    reset = 0; step();
    chk("t6_instr", 64'(id_instruction), 64'h1000);
    chk("t6_has", 64'(id_has_imm), 64'd0);

    // Randomized phase
    for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
    for (int c = 0; c < 600; c++) begin
      reset    = ($urandom_range(99) < 2);
      redirect = ($urandom_range(99) < 10);
      stall    = ($urandom_range(99) < 25);
      case ($urandom_range(2))
        0: redirect_pc = PCW'($urandom);
        1: redirect_pc = PCW'($urandom_range(255));
        default: redirect_pc = 32'hFFFF_FFFF - PCW'($urandom_range(1));
      endcase
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage_v2.md
Name: fetch_stage_v2

Overview:
Parametrised instruction-fetch stage with IF/ID pipeline register. It supports:
- stall and branch redirect/flush
- one-word and two-word instructions (opcode word followed by an immediate word)
- a registered valid flag

It drives a combinational-read instruction memory and feeds the decode stage. It supersedes the fixed 16-bit fetch stage.

Parameters:
IW, 16, instruction/memory word width in bits
PCW, 32, program counter width in bits
RESET_PC, 32, PC value loaded on reset (first instruction-memory address)
EXT_BIT, 0, bit index of the instruction word; 1 marks a two-word (immediate) instruction

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC, state and IF/ID register
redirect  input  1  branch/jump taken; load redirect_pc and flush
redirect_pc  input  PCW  target address for redirect
imem_addr  output  PCW  instruction memory word address (= PC, combinational)
imem_data  input  IW  word at imem_addr, same cycle
id_valid  output  1  IF/ID register holds a real instruction
id_instruction  output  IW  opcode word
id_immediate  output  IW  immediate word (0 when id_has_imm=0)
id_has_imm  output  1  instruction was two-word
id_pc  output  PCW  address of the opcode word
id_pc_next  output  PCW  address following the whole instruction

Behaviour:
- Reset (synchronous, highest priority):
  - pc=RESET_PC, state=FETCH, first_word=0, first_pc=0.
  - id_valid=0; id_instruction, id_immediate, id_has_imm, id_pc and id_pc_next all 0.
  - Reset mid two-word fetch discards the partial instruction.
- imem_addr = pc at all times (combinational). pc arithmetic is modulo 2^PCW; pc+1 wraps to 0 from all-ones.
- Priority per edge: reset > redirect > stall > normal.
- Redirect, regardless of state or stall:
  - pc<=redirect_pc, state<=FETCH, id_valid<=0.
  - Other id_* fields hold.
  - A pending first word is discarded.
  - The first fetch at redirect_pc happens the next cycle.
- Stall (without redirect): pc, state, first_word, first_pc and all id_* hold. No memory word is consumed.
- State FETCH, normal, imem_data[EXT_BIT]=0:
  - id_valid<=1, id_instruction<=imem_data, id_immediate<=0, id_has_imm<=0.
  - id_pc<=pc, id_pc_next<=pc+1, pc<=pc+1.
  - Latency: word at address A appears on id_* one cycle after pc=A.
- State FETCH, normal, imem_data[EXT_BIT]=1:
  - first_word<=imem_data, first_pc<=pc, pc<=pc+1, state<=FETCH_IMM.
  - id_valid<=0 (one bubble).
- State FETCH_IMM, normal:
  - id_valid<=1, id_instruction<=first_word, id_immediate<=imem_data, id_has_imm<=1.
  - id_pc<=first_pc, id_pc_next<=pc+1, pc<=pc+1, state<=FETCH.
  - The immediate word's EXT_BIT is ignored.
- Throughput: 1 instruction/cycle for one-word; 1 per 2 cycles for two-word.
- id_* change only on a normal-cycle edge or on reset. id_valid also clears on redirect.
- Two-word instruction whose immediate address wraps: pc wraps to 0, and the immediate is fetched from address 0.

Test Plan:
1. Reset with IW=16, RESET_PC=32 -> imem_addr=32, id_valid=0, all id_* 0. Release reset; memory[32]=0x1000 -> next edge id_valid=1, id_instruction=0x1000, id_pc=32, id_pc_next=33, imem_addr=33.
2. Memory[33]=0x2001 (EXT_BIT=0 set), memory[34]=0xABCD:
   - edge 1 -> id_valid=0.
   - edge 2 -> id_valid=1, id_instruction=0x2001, id_immediate=0xABCD, id_has_imm=1, id_pc=33, id_pc_next=35.
3. stall=1 for 3 cycles during FETCH_IMM (after the 0x2001 word) -> pc stays 34, id_* unchanged. stall=0 -> the two-word result of scenario 2 is produced on the following edge.
4. redirect=1, redirect_pc=100 in FETCH_IMM with stall=1 simultaneously -> next cycle imem_addr=100, id_valid=0, state FETCH. The partial 0x2001 is never emitted. Memory[100]=0x0042 -> id_instruction=0x0042, id_pc=100.
5. Two-word fetch at redirect_pc=0xFFFFFFFF, memory[0]=0x5555 -> id_pc=0xFFFFFFFF, id_immediate=0x5555, id_pc_next=1.
6. reset asserted one cycle after a first-word fetch -> pc=32, id_valid=0, state FETCH. No two-word output appears after release.
